q_pulse_serializer: RTL and testbench
=====================================

// Module: q_pulse_serializer
// PURPOSE
//  Synthesizable transmitter for the serialized-charge pulse protocol. Consumed by the Q measurement receiver in top.
//  Converts a parallel charge word into a train of fixed-width pulses on q_serialized, one pulse per Q_PER_PULSE of charge.
//  Ends each train with a silent gap long enough to expire the receiver watchdog.
//  Used as the on-chip replacement for the behavioural resonant system emulator, and as a loopback source for top.
// PARAMETERS
//  BUS_WIDTH      10                charge word / pulse counter width
//  Q_PER_PULSE    1                 charge units represented by one pulse (>=1)
//  PULSE_DURATION 3                 clk cycles q_serialized is high per pulse (>=1)
//  GAP_DURATION   3                 clk cycles low between consecutive pulses (>=1)
//  WTD_BUS_WIDTH  3                 receiver watchdog width
//  END_GAP        2**WTD_BUS_WIDTH  clk cycles low after the last pulse (>=1)
// PORTS
//  clk           in   1          system clock, rising edge
//  rst           in   1          synchronous, active-high reset
//  enable        in   1          1 = advance, 0 = freeze all state and outputs
//  in_valid      in   1          q_in is valid
//  in_ready      out  1          block idle, will accept q_in
//  q_in          in   BUS_WIDTH  charge to serialize
//  q_serialized  out  1          pulse train, registered
//  busy          out  1          train in progress (incl. END_GAP)
//  done          out  1          1-cycle strobe, train and end gap complete
//  q_residue     out  BUS_WIDTH  q_in % Q_PER_PULSE of last accepted word
// BEHAVIOUR
//  Reset (rst=1 at posedge, any state): q_serialized=0, busy=0, done=0, in_ready=1, q_residue=0, state IDLE.
//  Reset aborts a train mid-pulse; q_serialized is low the following cycle.
//  Accept: in_valid && in_ready && enable at edge T.
//   Latches N = q_in / Q_PER_PULSE (floor) and q_residue = q_in % Q_PER_PULSE.
//   Division is compile-time specialised: shift when Q_PER_PULSE is a power of 2, iterative subtract otherwise.
//   The division completes before T+1.
//  FSM IDLE -> HIGH -> LOW -> HIGH ... -> END_GAP -> DONE -> IDLE:
//   IDLE:    in_ready=1. On accept: N>0 -> HIGH, N==0 -> END_GAP.
//   HIGH:    q_serialized=1 for PULSE_DURATION cycles, then decrement the pulse count.
//            Count reaches 0 -> END_GAP; otherwise -> LOW.
//   LOW:     q_serialized=0 for GAP_DURATION cycles -> HIGH.
//   END_GAP: q_serialized=0 for END_GAP cycles -> DONE.
//   DONE:    done=1 for one cycle, busy=0, in_ready=1. Returns to IDLE; an accept in this cycle is legal and starts a new train.
//  Timing: first high cycle is T+1; train spans N*PULSE_DURATION + (N-1)*GAP_DURATION cycles.
//   done asserts at T+1 + train + END_GAP, with train = 0 when N==0.
//  busy=1 from T+1 until the cycle before done.
//  in_valid while busy is ignored; q_in is not re-sampled.
//  enable=0: phase counter, pulse count, state and all outputs hold. A HIGH phase is stretched, not split. done is never asserted while enable=0.
//  Widths: pulse count is BUS_WIDTH bits (max 2**BUS_WIDTH-1, no overflow).
//   Phase counter width is $clog2(max(PULSE_DURATION, GAP_DURATION, END_GAP)+1).
//  No combinational path from inputs to q_serialized.
// STRUCTURE
//  Package q_ser_pkg: state enum (IDLE, HIGH, LOW, END_GAP, DONE) and a phase-length function used by both this block and its bench.
//  Sub-module: phase_timer.
//   Loadable down-counter with load, enable and expired.
//   Reused for the HIGH, LOW and END_GAP phases.
//  Top level holds the FSM, the pulse counter and the residue register.
// TESTING (defaults unless stated; T = accept edge)
//  1 q_in=5       -> 5 pulses of 3 high / 3 low; cycles T+1..T+27 active, T+28..T+35 low; done at T+36 only.
//  2 q_in=0       -> q_serialized never high; busy T+1..T+8; done at T+9.
//  3 Q_PER_PULSE=2, q_in=7 -> exactly 3 pulses; q_residue=1; done at T+1+15+8=T+24.
//  4 enable=0 for 4 cycles in 2nd HIGH of q_in=3 -> that pulse high 7 cycles; others 3; done delayed by exactly 4.
//  5 in_valid=1 with q_in=9 throughout a q_in=2 train -> 2 pulses, then 9 accepted in DONE cycle; rst mid 3rd pulse -> q_serialized=0, in_ready=1 next cycle.
//  6 q_in=1023 -> 1023 pulses counted by loopback into top q measurement; q_measured=1023; no counter wrap.

Source files
------------

// File: rtl/q_pulse_serializer_pkg.sv
// Shared types and helpers for the serialized-charge pulse transmitter.
// Phase lengths are resolved here so the block and its bench agree on them.
package q_ser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_END_GAP,
        S_DONE
    } state_t;

    function automatic int unsigned phase_len(
        input state_t      s,
        input int unsigned pulse_d,
        input int unsigned gap_d,
        input int unsigned end_d
    );
        case (s)
            S_HIGH:    return pulse_d;
            S_LOW:     return gap_d;
            S_END_GAP: return end_d;
            default:   return 1;
        endcase
    endfunction

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/q_pulse_serializer_timer.sv
// Loadable down-counter timing the HIGH, LOW and END_GAP phases.
// o_expired marks the last cycle of the loaded phase.
module phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/q_pulse_serializer.sv
// Serialized-charge pulse transmitter: one fixed-width pulse per Q_PER_PULSE
// of accepted charge, followed by an end gap that expires the receiver watchdog.
module q_pulse_serializer
    import q_ser_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = 10,
    parameter int unsigned Q_PER_PULSE    = 1,
    parameter int unsigned PULSE_DURATION = 3,
    parameter int unsigned GAP_DURATION   = 3,
    parameter int unsigned WTD_BUS_WIDTH  = 3,
    parameter int unsigned END_GAP        = 2 ** WTD_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] q_in,
    output logic                 q_serialized,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] q_residue
);

    localparam int unsigned LP_HIGH_LEN = phase_len(S_HIGH, PULSE_DURATION, GAP_DURATION, END_GAP);
    localparam int unsigned LP_LOW_LEN  = phase_len(S_LOW, PULSE_DURATION, GAP_DURATION, END_GAP);
    localparam int unsigned LP_END_LEN  = phase_len(S_END_GAP, PULSE_DURATION, GAP_DURATION, END_GAP);
    localparam int unsigned LP_TW       = $clog2(max3(LP_HIGH_LEN, LP_LOW_LEN, LP_END_LEN) + 1);

    localparam logic [LP_TW-1:0] LP_HIGH_LD = LP_TW'(LP_HIGH_LEN - 1);
    localparam logic [LP_TW-1:0] LP_LOW_LD  = LP_TW'(LP_LOW_LEN - 1);
    localparam logic [LP_TW-1:0] LP_END_LD  = LP_TW'(LP_END_LEN - 1);

    localparam bit LP_POW2 = ((Q_PER_PULSE & (Q_PER_PULSE - 1)) == 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BUS_WIDTH-1:0] r_cnt;
    logic [BUS_WIDTH-1:0] r_residue;
    logic                 r_q_ser;
    logic [BUS_WIDTH-1:0] w_quot;
    logic [BUS_WIDTH-1:0] w_rem;
    logic                 w_accept;
    logic                 w_dec;
    logic                 w_load;
    logic [LP_TW-1:0]     w_load_val;
    logic                 w_expired;

    // Division resolves combinationally so N is ready at the accept edge.
    generate
        if (LP_POW2) begin : g_div_shift
            localparam int unsigned          LP_SHIFT = $clog2(Q_PER_PULSE);
            localparam logic [BUS_WIDTH-1:0] LP_MASK  = BUS_WIDTH'(Q_PER_PULSE - 1);
            assign w_quot = q_in >> LP_SHIFT;
            assign w_rem  = q_in & LP_MASK;
        end else begin : g_div_sub
            localparam logic [BUS_WIDTH:0] LP_Q = (BUS_WIDTH + 1)'(Q_PER_PULSE);
            always_comb begin
                logic [BUS_WIDTH:0]   v_rem;
                logic [BUS_WIDTH-1:0] v_num;
                v_rem  = '0;
                v_num  = q_in;
                w_quot = '0;
                for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
                    v_rem  = {v_rem[BUS_WIDTH-1:0], v_num[BUS_WIDTH-1]};
                    v_num  = v_num << 1;
                    w_quot = w_quot << 1;
                    if (v_rem >= LP_Q) begin
                        v_rem     = v_rem - LP_Q;
                        w_quot[0] = 1'b1;
                    end
                end
                w_rem = v_rem[BUS_WIDTH-1:0];
            end
        end
    endgenerate

    phase_timer #(
        .WIDTH (LP_TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_en       (enable),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_dec       = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    if (w_quot != '0) begin
                        w_state_nxt = S_HIGH;
                        w_load_val  = LP_HIGH_LD;
                    end else begin
                        w_state_nxt = S_END_GAP;
                        w_load_val  = LP_END_LD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HIGH: begin
                if (w_expired) begin
                    w_dec  = 1'b1;
                    w_load = 1'b1;
                    if (r_cnt == BUS_WIDTH'(1)) begin
                        w_state_nxt = S_END_GAP;
                        w_load_val  = LP_END_LD;
                    end else begin
                        w_state_nxt = S_LOW;
                        w_load_val  = LP_LOW_LD;
                    end
                end
            end
            S_LOW: begin
                if (w_expired) begin
                    w_state_nxt = S_HIGH;
                    w_load      = 1'b1;
                    w_load_val  = LP_HIGH_LD;
                end
            end
            S_END_GAP: begin
                if (w_expired) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_residue <= '0;
            r_q_ser   <= 1'b0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_q_ser <= (w_state_nxt == S_HIGH);
            if (w_accept) begin
                r_cnt     <= w_quot;
                r_residue <= w_rem;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign q_serialized = r_q_ser;
    assign q_residue    = r_residue;
    assign in_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy         = (r_state == S_HIGH) || (r_state == S_LOW) || (r_state == S_END_GAP);
    // A frozen DONE state must not strobe; the strobe waits for enable.
    assign done         = (r_state == S_DONE) && enable;

endmodule

// File: tb/tb_q_pulse_serializer.sv
// Directed bench for q_pulse_serializer: per-cycle waveform checks of pulse
// trains, stall, back-to-back accept, mid-train reset and full-scale charge.
module tb_q_pulse_serializer;

    localparam int unsigned BW = 10;
    localparam int unsigned P  = 3;
    localparam int unsigned G  = 3;
    localparam int unsigned E  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;

    logic          in_valid;
    logic [BW-1:0] q_in;
    logic          in_ready, q_ser, busy, done;
    logic [BW-1:0] q_res;

    logic          v2;
    logic [BW-1:0] q2_in;
    logic          rdy2, qs2, busy2, done2;
    logic [BW-1:0] res2;

    logic          v3;
    logic [BW-1:0] q3_in;
    logic          rdy3, qs3, busy3, done3;
    logic [BW-1:0] res3;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pulses, highs;

    always #5 clk = ~clk;

    q_pulse_serializer #(
        .BUS_WIDTH (BW), .Q_PER_PULSE (1), .PULSE_DURATION (P), .GAP_DURATION (G), .WTD_BUS_WIDTH (3)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable), .in_valid (in_valid), .in_ready (in_ready),
        .q_in (q_in), .q_serialized (q_ser), .busy (busy), .done (done), .q_residue (q_res)
    );

    q_pulse_serializer #(
        .BUS_WIDTH (BW), .Q_PER_PULSE (2), .PULSE_DURATION (P), .GAP_DURATION (G), .WTD_BUS_WIDTH (3)
    ) dut2 (
        .clk (clk), .rst (rst), .enable (enable), .in_valid (v2), .in_ready (rdy2),
        .q_in (q2_in), .q_serialized (qs2), .busy (busy2), .done (done2), .q_residue (res2)
    );

    q_pulse_serializer #(
        .BUS_WIDTH (BW), .Q_PER_PULSE (3), .PULSE_DURATION (P), .GAP_DURATION (G), .WTD_BUS_WIDTH (3)
    ) dut3 (
        .clk (clk), .rst (rst), .enable (enable), .in_valid (v3), .in_ready (rdy3),
        .q_in (q3_in), .q_serialized (qs3), .busy (busy3), .done (done3), .q_residue (res3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called in cycle T+1. Optionally holds enable low from cycle k0 for len cycles.
    task automatic run_train(input string tag, input int unsigned sel, input int unsigned n,
                             input int unsigned k0, input int unsigned len,
                             output int unsigned n_pulses, output int unsigned n_highs);
        int unsigned a, last, m;
        logic [3:0]  obs, exp;
        logic        prev;
        a        = (n == 0) ? 0 : n * P + (n - 1) * G;
        last     = a + E + 1 + len;
        n_pulses = 0;
        n_highs  = 0;
        prev     = 1'b0;
        for (int unsigned k = 1; k <= last; k++) begin
            if (len != 0 && k >= k0 && k <= k0 + len) m = k0;
            else if (len != 0 && k > k0 + len)        m = k - len;
            else                                      m = k;
            case (sel)
                1:       obs = {qs2, busy2, done2, rdy2};
                2:       obs = {qs3, busy3, done3, rdy3};
                default: obs = {q_ser, busy, done, in_ready};
            endcase
            exp[3] = (m <= a) && (((m - 1) % (P + G)) < P);
            exp[2] = (m <= a + E);
            exp[1] = (m == a + E + 1) && enable;
            exp[0] = (m == a + E + 1);
            check($sformatf("%s k%0d q_serialized", tag, k), 32'(obs[3]), 32'(exp[3]));
            check($sformatf("%s k%0d busy", tag, k),         32'(obs[2]), 32'(exp[2]));
            check($sformatf("%s k%0d done", tag, k),         32'(obs[1]), 32'(exp[1]));
            check($sformatf("%s k%0d in_ready", tag, k),     32'(obs[0]), 32'(exp[0]));
            if (obs[3] && !prev) n_pulses++;
            if (obs[3]) n_highs++;
            prev = obs[3];
            if (len != 0 && k == k0)       enable = 1'b0;
            if (len != 0 && k == k0 + len) enable = 1'b1;
            if (k != last) tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b0;
        q_in     = '0;
        v2       = 1'b0;
        q2_in    = '0;
        v3       = 1'b0;
        q3_in    = '0;
        tick();
        tick();
        check("rst q_serialized", 32'(q_ser), 32'd0);
        check("rst busy",         32'(busy), 32'd0);
        check("rst done",         32'(done), 32'd0);
        check("rst in_ready",     32'(in_ready), 32'd1);
        check("rst q_residue",    32'(q_res), 32'd0);
        rst = 1'b0;
        tick();

        // enable=0 blocks acceptance while idle
        enable   = 1'b0;
        in_valid = 1'b1;
        q_in     = 10'd4;
        tick();
        tick();
        check("frozen idle busy", 32'(busy), 32'd0);
        check("frozen idle q",    32'(q_ser), 32'd0);
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();

        // 1: five pulses
        check("t1 ready before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        q_in     = 10'd5;
        tick();
        in_valid = 1'b0;
        run_train("t1", 0, 5, 0, 0, pulses, highs);
        check("t1 pulses", pulses, 32'd5);
        check("t1 highs", highs, 32'd15);
        check("t1 residue", 32'(q_res), 32'd0);
        tick();

        // 2: zero charge, end gap only
        in_valid = 1'b1;
        q_in     = 10'd0;
        tick();
        in_valid = 1'b0;
        run_train("t2", 0, 0, 0, 0, pulses, highs);
        check("t2 pulses", pulses, 32'd0);
        tick();

        // 3: Q_PER_PULSE=2 (shift) and Q_PER_PULSE=3 (subtract)
        v2    = 1'b1;
        q2_in = 10'd7;
        tick();
        v2 = 1'b0;
        check("t3 residue q2", 32'(res2), 32'd1);
        run_train("t3", 1, 3, 0, 0, pulses, highs);
        check("t3 pulses q2", pulses, 32'd3);
        tick();
        v3    = 1'b1;
        q3_in = 10'd11;
        tick();
        v3 = 1'b0;
        check("t3 residue q3", 32'(res3), 32'd2);
        run_train("t3b", 2, 3, 0, 0, pulses, highs);
        check("t3 pulses q3", pulses, 32'd3);
        tick();

        // 4: stall during second HIGH phase (cycles 7..9)
        in_valid = 1'b1;
        q_in     = 10'd3;
        tick();
        in_valid = 1'b0;
        run_train("t4", 0, 3, 8, 4, pulses, highs);
        check("t4 pulses", pulses, 32'd3);
        check("t4 highs", highs, 32'd13);
        tick();

        // 5: in_valid held through a train, accepted again in DONE, then reset mid-pulse
        in_valid = 1'b1;
        q_in     = 10'd2;
        tick();
        q_in = 10'd9;
        run_train("t5", 0, 2, 0, 0, pulses, highs);
        check("t5 pulses", pulses, 32'd2);
        tick();
        q_in = 10'd0;
        check("t5 second busy", 32'(busy), 32'd1);
        check("t5 second q", 32'(q_ser), 32'd1);
        check("t5 second ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 13; i++) tick();
        check("t5 third pulse q", 32'(q_ser), 32'd1);
        check("t5 third pulse busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("t5 rst q", 32'(q_ser), 32'd0);
        check("t5 rst ready", 32'(in_ready), 32'd1);
        check("t5 rst busy", 32'(busy), 32'd0);
        tick();

        // 6: full-scale charge
        in_valid = 1'b1;
        q_in     = 10'd1023;
        tick();
        in_valid = 1'b0;
        run_train("t6", 0, 1023, 0, 0, pulses, highs);
        check("t6 pulses", pulses, 32'd1023);
        check("t6 highs", highs, 32'd3069);
        tick();
        check("t6 idle ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
